// File: rtl/imem_prefetch_buffer_pkg.sv
// Shared definitions for the instruction prefetch buffer: FIFO entry layout,
// the NOOP presented when no instruction is available, and the default reset PC.
package imem_prefetch_buffer_pkg;

    localparam logic [31:0] NOOP_INST        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } fifo_entry_t;

endpackage

// File: rtl/imem_prefetch_buffer_prefetch_fifo.sv
// Power-of-two FIFO of {pc, ir} entries; pointers carry one extra wrap bit so
// full and empty are distinguishable. Clear wins over push and pop.
module imem_prefetch_buffer_prefetch_fifo
    import imem_prefetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        push,
    input  fifo_entry_t push_data,
    input  logic        pop,
    output fifo_entry_t head,
    output logic [AW:0] count,
    output logic        full,
    output logic        empty
);

    fifo_entry_t mem_q [DEPTH];
    fifo_entry_t mem_d [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign count = wr_ptr_q - rd_ptr_q;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push && !full) begin
                mem_d[wr_ptr_q[AW-1:0]] = push_data;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // The credit scheme upstream must never present a kept response to a full FIFO.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && full && !clear));
        end
    end

endmodule

// File: rtl/imem_prefetch_buffer.sv
// Sequential instruction prefetcher with credit-limited requests, redirect flush
// via a drop counter, and optional perf counters (define PREFETCH_PERF_EN).
module imem_prefetch_buffer
    import imem_prefetch_buffer_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_npc,
    output logic [31:0] inst_ir
`ifdef PREFETCH_PERF_EN
    ,
    output logic [31:0] perf_req_cnt,
    output logic [31:0] perf_drop_cnt,
    output logic [31:0] perf_empty_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;

    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
    fifo_entry_t   fifo_head, fifo_wdata;
    logic [CW:0]   credits_used;
    logic          req_fire, resp_live, resp_drop, resp_keep;
    logic [31:0]   redirect_target;
    logic          redirect_unused;

    assign redirect_target = {redirect_pc[31:2], 2'b00};
    assign redirect_unused = ^redirect_pc[1:0];

    // Buffered plus in-flight never exceeds DEPTH, so kept responses always fit.
    assign credits_used   = {1'b0, fifo_count} + {1'b0, inflight_q};
    assign imem_req_valid = !rst && !redirect_valid && (credits_used < DEPTH_C);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is stale (e.g. issued before reset).
    assign resp_live = imem_resp_valid && (inflight_q != '0);
    assign resp_drop = resp_live && (redirect_valid || (drop_cnt_q != '0));
    assign resp_keep = resp_live && !resp_drop;

    assign fifo_push  = resp_keep;
    assign fifo_pop   = inst_valid && inst_ready && !redirect_valid;
    assign fifo_wdata = '{pc: resp_pc_q, ir: imem_resp_data};

    imem_prefetch_buffer_prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_valid),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign inst_valid = !fifo_empty;
    assign inst_pc    = inst_valid ? fifo_head.pc : 32'h0;
    assign inst_npc   = inst_pc + 32'd4;
    assign inst_ir    = inst_valid ? fifo_head.ir : NOOP_INST;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        drop_cnt_d = drop_cnt_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(resp_live);
        if (redirect_valid) begin
            fetch_pc_d = redirect_target;
            resp_pc_d  = redirect_target;
            drop_cnt_d = inflight_q - CW'(resp_live);
        end else begin
            if (req_fire)  fetch_pc_d = fetch_pc_q + 32'd4;
            if (resp_keep) resp_pc_d  = resp_pc_q + 32'd4;
            if (resp_drop) drop_cnt_d = drop_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(resp_keep && fifo_full));
        end
    end

`ifdef PREFETCH_PERF_EN
    logic [31:0] perf_req_q, perf_req_d;
    logic [31:0] perf_drop_q, perf_drop_d;
    logic [31:0] perf_empty_q, perf_empty_d;

    always_comb begin
        perf_req_d   = perf_req_q;
        perf_drop_d  = perf_drop_q;
        perf_empty_d = perf_empty_q;
        if (req_fire && (perf_req_q != '1))     perf_req_d   = perf_req_q + 32'd1;
        if (resp_drop && (perf_drop_q != '1))   perf_drop_d  = perf_drop_q + 32'd1;
        if (!inst_valid && (perf_empty_q != '1)) perf_empty_d = perf_empty_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_req_q   <= '0;
            perf_drop_q  <= '0;
            perf_empty_q <= '0;
        end else begin
            perf_req_q   <= perf_req_d;
            perf_drop_q  <= perf_drop_d;
            perf_empty_q <= perf_empty_d;
        end
    end

    assign perf_req_cnt   = perf_req_q;
    assign perf_drop_cnt  = perf_drop_q;
    assign perf_empty_cnt = perf_empty_q;
`endif

endmodule

// File: tb/tb_imem_prefetch_buffer.sv
// Directed bench for imem_prefetch_buffer with an in-order variable-latency
// memory model; perf counters are checked when PREFETCH_PERF_EN is defined.
module tb_imem_prefetch_buffer;
    import imem_prefetch_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_pc, inst_npc, inst_ir;
`ifdef PREFETCH_PERF_EN
    logic [31:0] perf_req_cnt, perf_drop_cnt, perf_empty_cnt;
`endif

    always #5 clk = ~clk;

    imem_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_pc         (inst_pc),
        .inst_npc        (inst_npc),
        .inst_ir         (inst_ir)
`ifdef PREFETCH_PERF_EN
        ,
        .perf_req_cnt    (perf_req_cnt),
        .perf_drop_cnt   (perf_drop_cnt),
        .perf_empty_cnt  (perf_empty_cnt)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] ir;
        int          cyc;
    } deliv_t;

    pend_t       pend[$];
    deliv_t      deliv[$];
    logic [31:0] reqlog[$];
    int          cyc;
    int          lat;
    int          checks;
    int          failures;
    logic        last_req_valid;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive memory response, sample handshakes, advance edge.
    task automatic tick();
        pend_t  p;
        deliv_t d;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        if (rst) begin
            pend.delete();
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            p = pend.pop_front();
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(p.addr);
        end
        #1;
        last_req_valid = imem_req_valid;
        if (!rst && imem_req_valid && imem_req_ready) begin
            p.addr = imem_req_addr;
            p.due  = cyc + lat;
            pend.push_back(p);
            reqlog.push_back(imem_req_addr);
        end
        if (!rst && inst_valid && inst_ready && !redirect_valid) begin
            d.pc  = inst_pc;
            d.npc = inst_npc;
            d.ir  = inst_ir;
            d.cyc = cyc;
            deliv.push_back(d);
        end
        @(posedge clk);
        #1;
        imem_resp_valid = 1'b0;
        cyc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;
        imem_req_ready = 1'b1;
        ticks(2);
        rst = 1'b0;
        cyc = 0;
        pend.delete();
        reqlog.delete();
        deliv.delete();
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0; lat = 1;
        imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_inst_valid", 32'(inst_valid), 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_inst_npc", inst_npc, 32'h4);
        chk("rst_inst_ir", inst_ir, 32'h0000_0013);

        // Streaming, L=1, always ready
        do_reset();
        lat = 1; inst_ready = 1'b1;
        ticks(8);
        chk("s_req0", reqlog[0], 32'h0);
        chk("s_req1", reqlog[1], 32'h4);
        chk("s_req2", reqlog[2], 32'h8);
        chk("s_ndeliv", 32'(deliv.size()), 32'd6);
        chk("s_pc0", deliv[0].pc, 32'h0);
        chk("s_ir0", deliv[0].ir, 32'hC0DE_0000);
        chk("s_cyc0", 32'(deliv[0].cyc), 32'd2);
        chk("s_pc1", deliv[1].pc, 32'h4);
        chk("s_cyc1", 32'(deliv[1].cyc), 32'd3);
        chk("s_npc1", deliv[1].npc, 32'h8);
`ifdef PREFETCH_PERF_EN
        chk("s_perf_req", perf_req_cnt, 32'd8);
        chk("s_perf_empty", perf_empty_cnt, 32'd2);
`endif

        // Stall for 10 cycles: FIFO fills to DEPTH and requests stop
        do_reset();
        lat = 1; inst_ready = 1'b0;
        ticks(10);
        chk("st_nreq", 32'(reqlog.size()), 32'd4);
        chk("st_req_valid", 32'(imem_req_valid), 32'h0);
        chk("st_inst_valid", 32'(inst_valid), 32'h1);
        chk("st_inst_pc", inst_pc, 32'h0);
        chk("st_ndeliv", 32'(deliv.size()), 32'd0);
        inst_ready = 1'b1;
        ticks(6);
        chk("st_ndeliv2", 32'(deliv.size()), 32'd6);
        chk("st_pc3", deliv[3].pc, 32'hC);
        chk("st_pc4", deliv[4].pc, 32'h10);
        chk("st_cyc4", 32'(deliv[4].cyc), 32'd14);
        chk("st_pc5", deliv[5].pc, 32'h14);
        chk("st_cyc5", 32'(deliv[5].cyc), 32'd15);

        // L=3, redirect to 0x100 with 3 in flight
        do_reset();
        lat = 3; inst_ready = 1'b1;
        ticks(3);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        chk("r3_req_blocked", 32'(last_req_valid), 32'h0);
        redirect_valid = 1'b0;
        ticks(6);
        chk("r3_req3", reqlog[3], 32'h100);
        chk("r3_ndeliv", 32'(deliv.size()), 32'd2);
        chk("r3_pc0", deliv[0].pc, 32'h100);
        chk("r3_ir0", deliv[0].ir, 32'hC0DE_0100);
        chk("r3_cyc0", 32'(deliv[0].cyc), 32'd8);
        chk("r3_pc1", deliv[1].pc, 32'h104);
`ifdef PREFETCH_PERF_EN
        chk("r3_perf_drop", perf_drop_cnt, 32'd3);
`endif

        // Redirect coinciding with a response while the head is being consumed
        do_reset();
        lat = 1; inst_ready = 1'b1;
        ticks(2);
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        chk("rc_req_blocked", 32'(last_req_valid), 32'h0);
        redirect_valid = 1'b0;
        chk("rc_flushed", 32'(inst_valid), 32'h0);
        ticks(3);
        chk("rc_req2", reqlog[2], 32'h40);
        chk("rc_ndeliv", 32'(deliv.size()), 32'd1);
        chk("rc_pc0", deliv[0].pc, 32'h40);
        chk("rc_ir0", deliv[0].ir, 32'hC0DE_0040);
`ifdef PREFETCH_PERF_EN
        chk("rc_perf_drop", perf_drop_cnt, 32'd1);
`endif

        // Back-to-back redirects 0x200 then 0x300, L=2
        do_reset();
        lat = 2; inst_ready = 1'b1;
        ticks(2);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_pc = 32'h300;
        tick();
        redirect_valid = 1'b0;
        ticks(5);
        chk("bb_nreq_first", reqlog[2], 32'h300);
        chk("bb_pc0", deliv[0].pc, 32'h300);
        chk("bb_ir0", deliv[0].ir, 32'hC0DE_0300);
        chk("bb_cyc0", 32'(deliv[0].cyc), 32'd7);

        // Wrap at top of address space; low redirect bits ignored
        do_reset();
        lat = 1; inst_ready = 1'b1;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFB;
        tick();
        redirect_valid = 1'b0;
        ticks(5);
        chk("w_req1", reqlog[1], 32'hFFFF_FFF8);
        chk("w_pc0", deliv[0].pc, 32'hFFFF_FFF8);
        chk("w_npc1", deliv[1].npc, 32'h0);
        chk("w_pc2", deliv[2].pc, 32'h0);
        chk("w_ir2", deliv[2].ir, 32'hC0DE_0000);

        // Reset asserted mid-stream with 2 in flight
        do_reset();
        lat = 3; inst_ready = 1'b1;
        ticks(2);
        chk("mr_inflight", 32'(reqlog.size()), 32'd2);
        rst = 1'b1;
        #1;
        chk("mr_req_valid", 32'(imem_req_valid), 32'h0);
        chk("mr_req_addr", imem_req_addr, 32'h0);
        chk("mr_inst_valid", 32'(inst_valid), 32'h0);
        chk("mr_inst_ir", inst_ir, 32'h0000_0013);
        tick();
        rst = 1'b0;
        cyc = 0;
        reqlog.delete();
        deliv.delete();
        ticks(5);
        chk("mr_req0", reqlog[0], 32'h0);
        chk("mr_nreq", 32'(reqlog.size()), 32'd4);
        chk("mr_ndeliv", 32'(deliv.size()), 32'd1);
        chk("mr_pc0", deliv[0].pc, 32'h0);
        chk("mr_cyc0", 32'(deliv[0].cyc), 32'd4);
`ifdef PREFETCH_PERF_EN
        chk("mr_perf_drop", perf_drop_cnt, 32'd0);
        chk("mr_perf_req", perf_req_cnt, 32'd4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
